// File: rtl/act_sched_if.sv
// Bundle of requester, shared-tanh and status signals around the act_sched scheduler.
// Handshake: an operand moves when req_valid[i] & req_ready[i] at a rising edge; requesters hold valid/data until then.
interface act_sched_if #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int LAT        = 4
);
  logic                         en;
  logic [NREQ-1:0]              req_valid;
  logic [NREQ*DATA_WIDTH-1:0]   req_data;
  logic [NREQ-1:0]              req_ready;
  logic                         tanh_rst;
  logic [DATA_WIDTH-1:0]        tanh_x;
  logic [DATA_WIDTH-1:0]        tanh_y;
  logic [NREQ-1:0]              rsp_valid;
  logic [DATA_WIDTH-1:0]        rsp_data;
  logic [$clog2(LAT+2)-1:0]     inflight;
  logic                         idle;

  modport slave (
    input  en, req_valid, req_data, tanh_y,
    output req_ready, tanh_rst, tanh_x, rsp_valid, rsp_data, inflight, idle
  );

  modport master (
    output en, req_valid, req_data, tanh_y,
    input  req_ready, tanh_rst, tanh_x, rsp_valid, rsp_data, inflight, idle
  );
endinterface

// File: rtl/act_sched.sv
// Round-robin scheduler sharing one pipelined tanh unit among NREQ requesters,
// tracking result ownership with a tag pipeline aligned to the unit's latency.
module act_sched #(
  parameter int NREQ        = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 12,
  parameter int LAT         = 4
) (
  input  logic       clk,
  input  logic       rst,
  act_sched_if.slave bus
);
  localparam int TW = $clog2(NREQ);
  localparam int IW = $clog2(LAT + 2);

  if (NREQ < 2 || NREQ > 8 || LAT < 1 || FRACT_WIDTH < 0 || FRACT_WIDTH >= DATA_WIDTH) begin : g_param_chk
    $error("act_sched: parameter out of range");
  end

  logic [TW-1:0]         ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] tanh_x_q, tanh_x_d;
  logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IW-1:0]         infl_q, infl_d;
  // Slot 0 lines up with tanh_x; slot LAT lines up with a valid tanh_y.
  logic [LAT:0]          pv_q, pv_d;
  logic [TW-1:0]         pt_q [LAT+1];

  logic [NREQ-1:0]       grant;
  logic [TW-1:0]         gnt_idx;
  logic                  found;
  logic                  xfer;
  logic                  ret;

  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = TW'(idx);
      end
    end
    if (found && bus.en && rst) grant[gnt_idx] = 1'b1;
  end

  assign xfer = |grant;
  assign ret  = pv_q[LAT];

  always_comb begin
    ptr_d       = xfer ? gnt_idx : ptr_q;
    tanh_x_d    = xfer ? bus.req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH] : tanh_x_q;
    pv_d        = {pv_q[LAT-1:0], xfer};
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (ret) begin
      rsp_valid_d[pt_q[LAT]] = 1'b1;
      rsp_data_d             = bus.tanh_y;
    end
    infl_d = infl_q;
    if (xfer && !ret)      infl_d = infl_q + IW'(1);
    else if (!xfer && ret) infl_d = infl_q - IW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q       <= TW'(NREQ - 1);
      tanh_x_q    <= '0;
      pv_q        <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      infl_q      <= '0;
    end else begin
      ptr_q       <= ptr_d;
      tanh_x_q    <= tanh_x_d;
      pv_q        <= pv_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      infl_q      <= infl_d;
    end
  end

  // Tags are qualified by pv_q, so they need no reset.
  always_ff @(posedge clk) begin
    pt_q[0] <= gnt_idx;
    for (int i = 1; i <= LAT; i++) pt_q[i] <= pt_q[i-1];
  end

  assign bus.req_ready = grant;
  assign bus.tanh_rst  = rst;
  assign bus.tanh_x    = tanh_x_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.inflight  = infl_q;
  assign bus.idle      = (infl_q == '0) && !(|bus.req_valid);
endmodule

// File: tb/tb_act_sched.sv
// Randomized bench for act_sched against a cycle-level reference model with a
// behavioural pipelined tanh stand-in and an expected-response queue.
module tb_act_sched;
  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int FW   = 12;
  localparam int LAT  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  act_sched_if #(.NREQ(NREQ), .DATA_WIDTH(DW), .LAT(LAT)) bus ();

  act_sched #(.NREQ(NREQ), .DATA_WIDTH(DW), .FRACT_WIDTH(FW), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in tanh: scaled by 3/4 and saturated at +/-1.0, LAT cycles deep.
  function automatic logic [DW-1:0] tanh_ref(logic [DW-1:0] x);
    int v;
    v = int'($signed(x));
    v = (v * 3) / 4;
    if (v > 4096)  v = 4096;
    if (v < -4096) v = -4096;
    return v[DW-1:0];
  endfunction

  logic [DW-1:0] hist [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) hist[i] <= hist[i-1];
    hist[0] <= tanh_ref(bus.tanh_x);
  end
  assign bus.tanh_y = hist[LAT-1];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic [31:0]   due;
    logic [7:0]    tag;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [NREQ-1:0] pend, keep;
  logic [DW-1:0]   pdata [NREQ];
  logic            en_v, rst_v;
  int              m_ptr, m_infl, last_gnt;
  logic [DW-1:0]   m_x, m_rsp;

  task automatic model_reset();
    m_ptr  = NREQ - 1;
    m_infl = 0;
    m_x    = '0;
    m_rsp  = '0;
    exp_q.delete();
  endtask

  task automatic check_cycle();
    int   g;
    int   j;
    logic ret;
    exp_t e;
    check("tanh_x", 32'(bus.tanh_x), 32'(m_x));
    check("inflight", 32'(bus.inflight), 32'(m_infl));
    check("tanh_rst", 32'(bus.tanh_rst), 32'(rst));
    if (exp_q.size() > 0 && int'(exp_q[0].due) == cyc) begin
      e = exp_q.pop_front();
      check("rsp_valid", 32'(bus.rsp_valid), 32'(1) << e.tag);
      check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
      m_rsp = e.data;
    end else begin
      check("rsp_valid_idle", 32'(bus.rsp_valid), 32'(0));
      check("rsp_data_hold", 32'(bus.rsp_data), 32'(m_rsp));
    end
    g = -1;
    if (rst && bus.en) begin
      for (int k = 1; k <= NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (g < 0 && pend[j]) g = j;
      end
    end
    check("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'(1) << g) : 32'(0));
    check("idle", 32'(bus.idle), 32'((m_infl == 0) && (pend == '0)));
    // Advance the model across the coming rising edge.
    if (!rst) begin
      model_reset();
      g = -1;
    end else begin
      ret = (exp_q.size() > 0) && (int'(exp_q[0].due) == cyc + 1);
      if (g >= 0) begin
        m_ptr = g;
        m_x   = pdata[g];
        e.due = 32'(cyc + LAT + 2);
        e.tag = 8'(g);
        e.data = tanh_ref(pdata[g]);
        exp_q.push_back(e);
        if (!keep[g]) pend[g] = 1'b0;
      end
      m_infl = m_infl + ((g >= 0) ? 1 : 0) - (ret ? 1 : 0);
    end
    last_gnt = g;
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    bus.req_valid = pend;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = pdata[i];
    bus.en = en_v;
    rst    = rst_v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check_cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    pend  = '0;
    keep  = '0;
    en_v  = 1'b1;
    rst_v = 1'b0;
    for (int i = 0; i < NREQ; i++) pdata[i] = '0;
    last_gnt = -1;
    model_reset();
    drive();

    repeat (3) step();
    rst_v = 1'b1;

    // single request on requester 2
    step();
    pend[2] = 1'b1; pdata[2] = 16'h1000;
    repeat (10) step();

    // all four continuously valid
    pdata[0] = 16'h0000; pdata[1] = 16'h1000; pdata[2] = 16'hF000; pdata[3] = 16'h5000;
    keep = 4'hF; pend = 4'hF;
    repeat (14) step();
    keep = '0;
    repeat (10) step();

    // fairness between 1 and 3, then 0 jumps in after a grant to 3
    pdata[1] = 16'(($urandom_range(0, 65535)));
    pdata[3] = 16'(($urandom_range(0, 65535)));
    keep = 4'b1010; pend = 4'b1010;
    repeat (5) step();
    for (int n = 0; n < 8 && bus.req_ready != 4'b1000; n++) step();
    check("fair_sync_on_3", 32'(bus.req_ready), 32'(4'b1000));
    pend[0] = 1'b1; pdata[0] = 16'h0800;
    step();
    check("fair_next_is_0", 32'(bus.req_ready), 32'(4'b0001));
    keep = '0;
    repeat (10) step();

    // enable low with requests pending
    keep = 4'hF; pend = 4'hF;
    repeat (3) step();
    en_v = 1'b0;
    repeat (3) begin
      step();
      check("en_low_no_grant", 32'(bus.req_ready), 32'(0));
    end
    en_v = 1'b1;
    repeat (3) step();
    keep = '0;
    repeat (10) step();

    // reset two cycles after three handshakes
    pend = 4'b0111;
    repeat (4) step();
    repeat (2) step();
    rst_v = 1'b0;
    step();
    rst_v = 1'b1;
    pend = 4'b1100;
    step();
    check("post_rst_inflight", 32'(bus.inflight), 32'(0));
    check("post_rst_lowest", 32'(bus.req_ready), 32'(4'b0100));
    repeat (12) step();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1'b1;
          pdata[i] = 16'($urandom_range(0, 65535));
        end
      end
      en_v  = ($urandom_range(0, 9) != 0);
      rst_v = ($urandom_range(0, 149) != 0);
      step();
    end

    en_v = 1'b1; rst_v = 1'b1;
    for (int n = 0; n < 40 && pend != '0; n++) step();
    repeat (LAT + 4) step();
    check("final_idle", 32'(bus.idle), 32'(1));
    check("final_inflight", 32'(bus.inflight), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
